// File: rtl/mux21_rr_arb.sv
// Two-source round-robin arbiter feeding a registered 2:1 data mux.
// The owner streams up to HOLD beats while the other source waits, then hands over.
module mux21_rr_arb #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] inp0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] inp1,
    output logic             ack1,
    output logic             sel,
    output logic [WIDTH-1:0] outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       dbg_state,
    output logic [3:0]       dbg_cnt,
    output logic             dbg_last
);
    // Handshake: a source beat moves when reqN & ackN in the same cycle; the
    // output beat moves when out_valid & out_ready in the same cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_C = 4'(HOLD);

    state_t           state_q;
    logic             last_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] outp_q;
    logic             valid_q;

    logic load_en;
    logic at_hold;

    assign load_en = !valid_q || out_ready;
    assign at_hold = (cnt_q == HOLD_C);

    // A saturated owner yields its beat on the cycle the other side is waiting.
    assign ack0 = (state_q == OWN0) && req0 && load_en && !(at_hold && req1);
    assign ack1 = (state_q == OWN1) && req1 && load_en && !(at_hold && req0);

    assign sel       = (state_q == OWN1);
    assign outp      = outp_q;
    assign out_valid = valid_q;
    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;
    assign dbg_last  = last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            outp_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (ack0 || ack1) begin
                outp_q  <= sel ? inp1 : inp0;
                valid_q <= 1'b1;
            end else if (load_en) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= OWN0;
                        cnt_q   <= 4'd0;
                    end else if (req1) begin
                        state_q <= OWN1;
                        cnt_q   <= 4'd0;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        last_q  <= 1'b0;
                        cnt_q   <= 4'd0;
                        state_q <= req1 ? OWN1 : IDLE;
                    end else if (at_hold && req1 && load_en) begin
                        last_q  <= 1'b0;
                        cnt_q   <= 4'd0;
                        state_q <= OWN1;
                    end else if (ack0 && !at_hold) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                OWN1: begin
                    if (!req1) begin
                        last_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= req0 ? OWN0 : IDLE;
                    end else if (at_hold && req0 && load_en) begin
                        last_q  <= 1'b1;
                        cnt_q   <= 4'd0;
                        state_q <= OWN0;
                    end else if (ack1 && !at_hold) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux21_rr_arb.sv
// Directed bench for mux21_rr_arb: stream sources, a grant/queue model checked
// every cycle, and literal pins for the key arbitration scenarios.
module tb_mux21_rr_arb;
    localparam int W    = 8;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0, out_ready = 1'b0;
    logic [W-1:0] inp0 = '0, inp1 = '0;
    logic         ack0, ack1, sel, out_valid, dbg_last;
    logic [W-1:0] outp;
    logic [1:0]   dbg_state;
    logic [3:0]   dbg_cnt;

    mux21_rr_arb #(.WIDTH(W), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .inp0(inp0), .ack0(ack0),
        .req1(req1), .inp1(inp1), .ack1(ack1),
        .sel(sel), .outp(outp), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt), .dbg_last(dbg_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: owner (-1 none), beats granted in this tenure, last served, output queue
    int           owner;
    int           run_len;
    int           last_srv;
    logic [W-1:0] m_outp;
    logic [W-1:0] exp_q[$];

    // per-cycle history of DUT outputs for the literal pins
    logic [63:0]  a0_h, a1_h, sel_h, valid_h;
    logic [W-1:0] outp_h[64];
    logic [3:0]   cnt_h[64];
    logic         last_h[64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        run_len  = 0;
        last_srv = 1;
        m_outp   = '0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0; inp0 = '0; inp1 = '0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_sel",   {31'd0, sel}, 0);
        chk("rst_outp",  {24'd0, outp}, 0);
        chk("rst_acks",  {30'd0, ack0, ack1}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Source n presents beats b+0, b+1, ... from cycle s onward until n beats are granted.
    // out_ready is low for cycles [stall_lo, stall_hi).
    task automatic run(input int n0, input int b0, input int s0,
                       input int n1, input int b1, input int s1,
                       input int ncyc, input int stall_lo, input int stall_hi);
        int  sent0, sent1, o;
        bit  r[2];
        bit  e_ack[2];
        bit  busy, e_valid;
        logic [W-1:0] d[2];
        sent0 = 0; sent1 = 0;
        a0_h = '0; a1_h = '0; sel_h = '0; valid_h = '0;
        for (int i = 0; i < ncyc; i++) begin
            r[0] = (i >= s0) && (sent0 < n0);
            r[1] = (i >= s1) && (sent1 < n1);
            d[0] = W'(b0 + sent0);
            d[1] = W'(b1 + sent1);
            req0 = r[0]; inp0 = d[0]; req1 = r[1]; inp1 = d[1];
            out_ready = !(i >= stall_lo && i < stall_hi);
            #4;
            e_valid = (exp_q.size() != 0);
            busy    = e_valid && !out_ready;
            for (int n = 0; n < 2; n++)
                e_ack[n] = (owner == n) && r[n] && !busy && !(run_len >= HOLD && r[1-n]);
            chk("ack0", {31'd0, ack0}, {31'd0, e_ack[0]});
            chk("ack1", {31'd0, ack1}, {31'd0, e_ack[1]});
            chk("sel", {31'd0, sel}, (owner == 1) ? 1 : 0);
            chk("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
            chk("outp", {24'd0, outp}, {24'd0, e_valid ? exp_q[0] : m_outp});
            chk("busy_state", {31'd0, dbg_state != 2'd0}, (owner != -1) ? 1 : 0);
            chk("last", {31'd0, dbg_last}, last_srv);
            if (owner != -1) chk("cnt", {28'd0, dbg_cnt}, run_len);
            a0_h[i] = ack0; a1_h[i] = ack1; sel_h[i] = sel; valid_h[i] = out_valid;
            outp_h[i] = outp; cnt_h[i] = dbg_cnt; last_h[i] = dbg_last;
            @(posedge clk);
            if (e_valid && out_ready) void'(exp_q.pop_front());
            for (int n = 0; n < 2; n++)
                if (e_ack[n]) begin
                    exp_q.push_back(d[n]);
                    m_outp = d[n];
                end
            if (e_ack[0]) sent0++;
            if (e_ack[1]) sent1++;
            if (owner == -1) begin
                if (r[0] && (!r[1] || last_srv == 1)) owner = 0;
                else if (r[1]) owner = 1;
                run_len = 0;
            end else begin
                o = 1 - owner;
                if (!r[owner]) begin
                    last_srv = owner;
                    owner    = r[o] ? o : -1;
                    run_len  = 0;
                end else if (run_len >= HOLD && r[o] && !busy) begin
                    last_srv = owner;
                    owner    = o;
                    run_len  = 0;
                end else if (e_ack[owner] && run_len < HOLD) begin
                    run_len++;
                end
            end
            #1;
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;

        // single source 0
        do_reset();
        run(1, 'h11, 0, 0, 0, 0, 5, 0, 0);
        chk("single_ack0_c1", {31'd0, a0_h[1]}, 1);
        chk("single_valid_c2", {31'd0, valid_h[2]}, 1);
        chk("single_outp_c2", {24'd0, outp_h[2]}, 'h11);
        chk("single_sel_c2", {31'd0, sel_h[2]}, 0);

        // tie after reset: 4 beats each with one switch cycle between
        do_reset();
        run(20, 'h00, 0, 20, 'h80, 0, 20, 0, 0);
        chk("tie_ack0", {20'd0, a0_h[11:0]}, 32'b1000_0001_1110);
        chk("tie_ack1", {20'd0, a1_h[11:0]}, 32'b0011_1100_0000);
        chk("tie_sel",  {20'd0, sel_h[11:0]}, 32'b0111_1100_0000);

        // back-pressure on source 1 stream
        do_reset();
        run(0, 0, 0, 6, 'hA0, 0, 14, 2, 5);
        chk("bp_ack1", {26'd0, a1_h[5:0]}, 32'b10_0010);
        chk("bp_hold_outp", {24'd0, outp_h[4]}, 'hA0);
        chk("bp_hold_cnt", {28'd0, cnt_h[4]}, 1);
        chk("bp_next_outp", {24'd0, outp_h[6]}, 'hA1);

        // early release of source 0 after two beats
        do_reset();
        run(2, 'h20, 0, 3, 'h50, 0, 10, 0, 0);
        chk("early_ack0", {28'd0, a0_h[3:0]}, 32'b0110);
        chk("early_sel_c4", {31'd0, sel_h[4]}, 1);
        chk("early_cnt_c4", {28'd0, cnt_h[4]}, 0);
        chk("early_last_c4", {31'd0, last_h[4]}, 0);
        chk("early_ack1_c4", {31'd0, a1_h[4]}, 1);

        // saturation on source 1, then source 0 arrives
        do_reset();
        run(3, 'h60, 11, 14, 'hC0, 0, 18, 0, 0);
        chk("sat_ack1", {21'd0, a1_h[10:0]}, 32'b111_1111_1110);
        chk("sat_cnt_c10", {28'd0, cnt_h[10]}, 4);
        chk("sat_switch_c11", {31'd0, a1_h[11]}, 0);
        chk("sat_ack0_c12", {31'd0, a0_h[12]}, 1);
        chk("sat_sel_c12", {31'd0, sel_h[12]}, 0);

        // asynchronous reset between edges while source 1 holds a beat
        do_reset();
        run(0, 0, 0, 5, 'h70, 0, 3, 0, 0);
        chk("pre_async_valid", {31'd0, out_valid}, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid}, 0);
        chk("async_sel", {31'd0, sel}, 0);
        chk("async_ack1", {31'd0, ack1}, 0);
        chk("async_outp", {24'd0, outp}, 0);
        do_reset();
        run(2, 'h30, 0, 2, 'h40, 0, 8, 0, 0);
        chk("post_rst_ack0", {31'd0, a0_h[1]}, 1);
        chk("post_rst_ack1", {31'd0, a1_h[1]}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
